// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UartTx frame scheduler.
package uart_sched_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_WAIT_NEXT = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first valid index at or after rrPtr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] reqValid,
  input  logic [IDX_W-1:0]   rrPtr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pickIdx
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest valid index is written last.
  always_comb begin
    pick    = '0;
    pickIdx = '0;
    cand    = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      cand = IDX_W'((32'(rrPtr) + 32'(k)) % NUM_REQ);
      if (reqValid[cand]) begin
        pick       = '0;
        pick[cand] = 1'b1;
        pickIdx    = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Frame-granular round-robin sharing of one UartTx between NUM_REQ byte producers.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned FRAME_TIMEOUT = 4800,
  parameter int unsigned TO_W          = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        reqValid,
  input  logic [BYTE_W*NUM_REQ-1:0] reqData,
  input  logic [NUM_REQ-1:0]        reqLast,
  output logic [NUM_REQ-1:0]        reqReady,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      uartSendRequest,
  output logic [BYTE_W-1:0]         uartSendData,
  input  logic                      uartSendComplete
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FRAME_TIMEOUT - 1);

  sched_state_e       state;
  logic [IDX_W-1:0]   rrPtr;
  logic [IDX_W-1:0]   ownerIdx;
  logic [IDX_W-1:0]   nextPtr;
  logic [IDX_W-1:0]   pickIdx;
  logic [NUM_REQ-1:0] pick;
  logic [BYTE_W-1:0]  holdReg;
  logic [BYTE_W-1:0]  pickByte;
  logic [BYTE_W-1:0]  ownerByte;
  logic               lastLatched;
  logic [TO_W-1:0]    toCnt;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .reqValid (reqValid),
    .rrPtr    (rrPtr),
    .pick     (pick),
    .pickIdx  (pickIdx)
  );

  assign pickByte     = reqData[BYTE_W*pickIdx +: BYTE_W];
  assign ownerByte    = reqData[BYTE_W*ownerIdx +: BYTE_W];
  assign nextPtr      = (32'(ownerIdx) == NUM_REQ - 1) ? '0 : ownerIdx + 1'b1;
  assign uartSendData = holdReg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      rrPtr           <= '0;
      ownerIdx        <= '0;
      holdReg         <= '0;
      lastLatched     <= 1'b0;
      toCnt           <= '0;
      reqReady        <= '0;
      grant           <= '0;
      busy            <= 1'b0;
      uartSendRequest <= 1'b0;
    end else begin
      reqReady <= '0;
      unique case (state)
        // UartTx has no reset, so a stale sendComplete must clear before a new grant.
        ST_IDLE: begin
          if (|reqValid && !uartSendComplete) begin
            grant           <= pick;
            ownerIdx        <= pickIdx;
            holdReg         <= pickByte;
            lastLatched     <= reqLast[pickIdx];
            reqReady        <= pick;
            uartSendRequest <= 1'b1;
            busy            <= 1'b1;
            state           <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (uartSendComplete) begin
            uartSendRequest <= 1'b0;
            state           <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!uartSendComplete) begin
            if (lastLatched) begin
              grant <= '0;
              busy  <= 1'b0;
              rrPtr <= nextPtr;
              state <= ST_IDLE;
            end else begin
              toCnt <= '0;
              state <= ST_WAIT_NEXT;
            end
          end
        end
        // Timeout is checked first so a byte arriving on the expiry cycle is refused.
        ST_WAIT_NEXT: begin
          if (toCnt == TO_LAST) begin
            grant <= '0;
            busy  <= 1'b0;
            rrPtr <= nextPtr;
            state <= ST_IDLE;
          end else if (reqValid[ownerIdx]) begin
            holdReg         <= ownerByte;
            lastLatched     <= reqLast[ownerIdx];
            reqReady        <= grant;
            uartSendRequest <= 1'b1;
            state           <= ST_SEND;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a behavioural UartTx stub (4 ticks per bit).
module tb_uart_tx_scheduler;

  localparam int TICKS = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  reqValid;
  logic [31:0] reqData;
  logic [3:0]  reqLast;
  logic [3:0]  reqReady;
  logic [3:0]  grant;
  logic        busy;
  logic        uartSendRequest;
  logic [7:0]  uartSendData;
  logic        uartSendComplete = 1'b0;

  int total = 0;
  int bad   = 0;

  uart_tx_scheduler #(
    .NUM_REQ       (4),
    .FRAME_TIMEOUT (20),
    .TO_W          (16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .reqValid         (reqValid),
    .reqData          (reqData),
    .reqLast          (reqLast),
    .reqReady         (reqReady),
    .grant            (grant),
    .busy             (busy),
    .uartSendRequest  (uartSendRequest),
    .uartSendData     (uartSendData),
    .uartSendComplete (uartSendComplete)
  );

  always #5 clock = ~clock;

  // UartTx stub: level handshake, no reset, optional extra hold of sendComplete.
  logic [9:0] shifter  = '0;
  logic       stubBusy = 1'b0;
  int         bitCnt   = 0;
  int         tickCnt  = 0;
  int         holdCnt  = 0;
  int         extraHold = 0;
  logic       serialOut;
  logic [7:0] sent[$];

  assign serialOut = stubBusy ? shifter[0] : 1'b1;

  always @(posedge clock) begin
    if (!stubBusy) begin
      if (uartSendRequest && !uartSendComplete) begin
        stubBusy <= 1'b1;
        shifter  <= {1'b1, uartSendData, 1'b0};
        bitCnt   <= 0;
        tickCnt  <= 0;
        sent.push_back(uartSendData);
      end else if (!uartSendRequest && uartSendComplete) begin
        if (holdCnt == 0) uartSendComplete <= 1'b0;
        else holdCnt <= holdCnt - 1;
      end
    end else if (tickCnt == TICKS - 1) begin
      tickCnt <= 0;
      if (bitCnt == 9) begin
        stubBusy         <= 1'b0;
        uartSendComplete <= 1'b1;
        holdCnt          <= extraHold;
      end else begin
        shifter <= shifter >> 1;
        bitCnt  <= bitCnt + 1;
      end
    end else begin
      tickCnt <= tickCnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Continuous monitors, sampled on the falling edge.
  int         rdyCnt[4];
  logic       sawGrant2 = 1'b0;
  logic       prevReq   = 1'b0;
  logic [7:0] prevData  = '0;
  logic [9:0] serWord   = '0;
  int         serCnt    = 0;

  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) if (reqReady[i]) rdyCnt[i]++;
      if (grant[2]) sawGrant2 = 1'b1;
      if (reqReady != 4'b0) check("ready_owner", {28'b0, reqReady & ~grant}, 0);
      if (uartSendRequest && prevReq) check("data_stable", {24'b0, uartSendData}, {24'b0, prevData});
    end
    prevReq  = uartSendRequest;
    prevData = uartSendData;
    if (stubBusy && tickCnt == 0) begin
      serWord = {serialOut, serWord[9:1]};
      serCnt++;
    end
  end

  task automatic clearLogs();
    sent.delete();
    for (int i = 0; i < 4; i++) rdyCnt[i] = 0;
    sawGrant2 = 1'b0;
    serWord   = '0;
    serCnt    = 0;
  endtask

  task automatic setReq(input int idx, input logic v, input logic [7:0] d, input logic l);
    reqValid[idx]       = v;
    reqData[8*idx +: 8] = d;
    reqLast[idx]        = l;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_idle"}, {31'b0, busy}, 0);
  endtask

  task automatic waitReady(input int idx, input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (reqReady[idx] !== 1'b1 && n < 500);
    check({tag, "_ready"}, {31'b0, reqReady[idx]}, 1);
  endtask

  task automatic waitSent(input int cnt, input string tag);
    int n = 0;
    while (sent.size() < cnt && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_sent_cnt"}, {31'b0, sent.size() >= cnt}, 1);
  endtask

  task automatic waitCmpl(input logic lvl, input string tag);
    int n = 0;
    while (uartSendComplete !== lvl && n < 500) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_cmpl"}, {31'b0, uartSendComplete}, {31'b0, lvl});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    reqValid = '0;
    reqData  = '0;
    reqLast  = '0;
    repeat (3) @(negedge clock);
    check("rst_grant", {28'b0, grant}, 0);
    check("rst_ready", {28'b0, reqReady}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_sreq", {31'b0, uartSendRequest}, 0);
    check("rst_data", {24'b0, uartSendData}, 0);
    reset = 1'b0;

    // Single byte 0xA5 from req0.
    clearLogs();
    setReq(0, 1'b1, 8'hA5, 1'b1);
    @(negedge clock);
    check("t1_ready", {28'b0, reqReady}, 4'b0001);
    check("t1_grant", {28'b0, grant}, 4'b0001);
    check("t1_sreq", {31'b0, uartSendRequest}, 1);
    check("t1_data", {24'b0, uartSendData}, 8'hA5);
    check("t1_busy", {31'b0, busy}, 1);
    setReq(0, 1'b0, 8'h00, 1'b0);
    waitIdle("t1");
    check("t1_cmpl_low", {31'b0, uartSendComplete}, 0);
    check("t1_grant_end", {28'b0, grant}, 0);
    check("t1_ready_cnt", rdyCnt[0], 1);
    check("t1_serial", {22'b0, serWord}, 10'h34A);
    check("t1_bits", serCnt, 10);
    check("t1_byte", {24'b0, sent[0]}, 8'hA5);

    // Contention between req0, req1, req3 with rrPtr back at 0.
    doReset();
    clearLogs();
    setReq(0, 1'b1, 8'h11, 1'b1);
    setReq(1, 1'b1, 8'h22, 1'b1);
    setReq(2, 1'b0, 8'h33, 1'b1);
    setReq(3, 1'b1, 8'h44, 1'b1);
    waitSent(4, "t2");
    reqValid = '0;
    waitIdle("t2");
    check("t2_b0", {24'b0, sent[0]}, 8'h11);
    check("t2_b1", {24'b0, sent[1]}, 8'h22);
    check("t2_b2", {24'b0, sent[2]}, 8'h44);
    check("t2_b3", {24'b0, sent[3]}, 8'h11);
    check("t2_no_grant2", {31'b0, sawGrant2}, 0);
    check("t2_ready0", rdyCnt[0], 2);

    // Three-byte frame from req2 while req0 waits.
    doReset();
    clearLogs();
    setReq(2, 1'b1, 8'h01, 1'b0);
    waitReady(2, "t3a");
    check("t3a_grant", {28'b0, grant}, 4'b0100);
    setReq(2, 1'b1, 8'h02, 1'b0);
    setReq(0, 1'b1, 8'h77, 1'b1);
    waitReady(2, "t3b");
    check("t3b_grant", {28'b0, grant}, 4'b0100);
    setReq(2, 1'b1, 8'h03, 1'b1);
    waitReady(2, "t3c");
    check("t3c_grant", {28'b0, grant}, 4'b0100);
    setReq(2, 1'b0, 8'h00, 1'b0);
    waitSent(4, "t3");
    setReq(0, 1'b0, 8'h00, 1'b0);
    waitIdle("t3");
    check("t3_b0", {24'b0, sent[0]}, 8'h01);
    check("t3_b1", {24'b0, sent[1]}, 8'h02);
    check("t3_b2", {24'b0, sent[2]}, 8'h03);
    check("t3_b3", {24'b0, sent[3]}, 8'h77);
    check("t3_ready2", rdyCnt[2], 3);

    // Owner req1 goes quiet mid-frame; req3 pending.
    doReset();
    clearLogs();
    setReq(1, 1'b1, 8'h55, 1'b0);
    setReq(3, 1'b1, 8'h44, 1'b1);
    waitReady(1, "t4");
    check("t4_grant", {28'b0, grant}, 4'b0010);
    setReq(1, 1'b0, 8'h00, 1'b0);
    waitCmpl(1'b1, "t4_hi");
    waitCmpl(1'b0, "t4_lo");
    repeat (20) @(negedge clock);
    check("t4_grant_held", {28'b0, grant}, 4'b0010);
    @(negedge clock);
    check("t4_revoked", {28'b0, grant}, 0);
    check("t4_busy_low", {31'b0, busy}, 0);
    @(negedge clock);
    check("t4_next_grant", {28'b0, grant}, 4'b1000);
    check("t4_next_ready", {28'b0, reqReady}, 4'b1000);
    setReq(3, 1'b0, 8'h00, 1'b0);
    waitIdle("t4");
    check("t4_b1", {24'b0, sent[1]}, 8'h44);

    // Reset while SEND is still waiting to see sendComplete.
    doReset();
    clearLogs();
    extraHold = 3;
    setReq(0, 1'b1, 8'h3C, 1'b1);
    waitReady(0, "t5");
    setReq(0, 1'b0, 8'h00, 1'b0);
    waitCmpl(1'b1, "t5_hi");
    check("t5_in_send", {31'b0, uartSendRequest}, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t5_sreq_rst", {31'b0, uartSendRequest}, 0);
    check("t5_grant_rst", {28'b0, grant}, 0);
    check("t5_busy_rst", {31'b0, busy}, 0);
    check("t5_data_rst", {24'b0, uartSendData}, 0);
    extraHold = 0;
    setReq(1, 1'b1, 8'h99, 1'b1);
    for (int n = 0; n < 50 && uartSendComplete === 1'b1; n++) begin
      check("t5_hold_off", {28'b0, grant}, 0);
      @(negedge clock);
    end
    check("t5_cmpl_lo", {31'b0, uartSendComplete}, 0);
    check("t5_not_yet", {28'b0, grant}, 0);
    @(negedge clock);
    check("t5_grant", {28'b0, grant}, 4'b0010);
    check("t5_sreq", {31'b0, uartSendRequest}, 1);
    setReq(1, 1'b0, 8'h00, 1'b0);
    waitIdle("t5");
    check("t5_b1", {24'b0, sent[1]}, 8'h99);

    // sendComplete held 5 extra cycles inside a two-byte frame.
    doReset();
    clearLogs();
    extraHold = 5;
    setReq(0, 1'b1, 8'h5A, 1'b0);
    waitReady(0, "t6");
    setReq(0, 1'b1, 8'h6B, 1'b1);
    waitCmpl(1'b1, "t6_hi");
    extraHold = 0;
    @(negedge clock);
    for (int n = 0; n < 50 && uartSendComplete === 1'b1; n++) begin
      check("t6_sreq_low", {31'b0, uartSendRequest}, 0);
      @(negedge clock);
    end
    check("t6_cmpl_lo", {31'b0, uartSendComplete}, 0);
    check("t6_sreq_lo0", {31'b0, uartSendRequest}, 0);
    @(negedge clock);
    check("t6_sreq_lo1", {31'b0, uartSendRequest}, 0);
    @(negedge clock);
    check("t6_sreq_hi", {31'b0, uartSendRequest}, 1);
    check("t6_ready", {28'b0, reqReady}, 4'b0001);
    check("t6_data", {24'b0, uartSendData}, 8'h6B);
    setReq(0, 1'b0, 8'h00, 1'b0);
    waitIdle("t6");
    check("t6_b0", {24'b0, sent[0]}, 8'h5A);
    check("t6_b1", {24'b0, sent[1]}, 8'h6B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UartTx serial transmitter between NUM_REQ byte producers, e.g. the ADC sample streamer and the status/command responder.
- Uses round-robin arbitration at frame granularity. A frame is one or more bytes terminated by reqLast. An owner keeps the transmitter until its last byte is sent or its inter-byte timeout expires.
- Sequences the UartTx level handshake on the UartTx side: hold sendRequest until sendComplete, then drop it and wait for sendComplete to clear.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FRAME_TIMEOUT, 4800, clock cycles an owner may leave reqValid low mid-frame before its grant is revoked (about 100 serial bit times at TICKS_PER_CYCLE=48).
- TO_W, 16, width of the timeout counter; must satisfy FRAME_TIMEOUT < 2**TO_W.

Ports:
- clock  in  1  system clock; also drives UartTx.
- reset  in  1  synchronous, active-high reset.
- reqValid  in  NUM_REQ  requester i has a byte on reqData[8i+7:8i].
- reqData  in  8*NUM_REQ  byte per requester.
- reqLast  in  NUM_REQ  the offered byte ends requester i's frame.
- reqReady  out  NUM_REQ  one-cycle pulse; the byte from requester i was latched, and the requester may change its data.
- grant  out  NUM_REQ  one-hot current frame owner; all zero when idle.
- busy  out  1  high in every state except IDLE.
- uartSendRequest  out  1  to UartTx.sendRequest.
- uartSendData  out  8  to UartTx.sendData; stable while uartSendRequest is high.
- uartSendComplete  in  1  from UartTx.sendComplete.

Behaviour:
- Reset values: all outputs 0; state IDLE; rrPtr 0; lastLatched 0; timeout counter 0. Reset mid-frame drops uartSendRequest on the next edge and discards the byte. The next grant still waits for uartSendComplete=0, because UartTx itself has no reset.
- States and transitions:
  - IDLE: if any reqValid and uartSendComplete=0, choose the first valid index at or after rrPtr (wrapping modulo NUM_REQ). On that edge: grant<=onehot(i), latch byte into holdReg, lastLatched<=reqLast[i], reqReady[i]<=1 for one cycle, uartSendRequest<=1, go to SEND. Latency from reqValid to uartSendRequest is 1 cycle.
  - SEND: hold uartSendRequest=1 and uartSendData=holdReg. When uartSendComplete=1: uartSendRequest<=0, go to RELEASE.
  - RELEASE: wait for uartSendComplete=0. Then go to IDLE if lastLatched=1, else go to WAIT_NEXT with the timeout counter cleared.
  - WAIT_NEXT: only the owner is considered; other reqValid lines are ignored.
    - If the owner's reqValid is high: latch byte, pulse reqReady, set lastLatched, assert uartSendRequest, go to SEND.
    - Else increment the counter. When the counter reaches FRAME_TIMEOUT-1, go to IDLE and revoke the grant.
- rrPtr update: on every transition into IDLE, rrPtr <= (owner index + 1) mod NUM_REQ. The new grant then takes effect from the following IDLE cycle, so there is at least one IDLE cycle between frames.
- grant is cleared on entry to IDLE and stays stable for the whole frame.
- reqReady is never asserted to a non-owner, never while in SEND or RELEASE, and at most once per byte.
- reqLast is sampled only together with the accepted byte.
- If the owner raises reqValid in the same cycle the timeout expires, the timeout wins: no byte is accepted and the requester must re-arbitrate.
- uartSendData changes only on an edge where uartSendRequest rises.

Decomposition:
- Package uart_sched_pkg holds:
  - state encoding constants ST_IDLE, ST_SEND, ST_RELEASE, ST_WAIT_NEXT (2 bits);
  - BYTE_W=8.
- One natural sub-module, rr_picker: combinational, takes reqValid[NUM_REQ] and rrPtr, returns a one-hot pick and its index. Instantiated once.
- The FSM, holdReg and timeout counter stay in uart_tx_scheduler.

Test Plan:
- Single byte: only req0 valid with 0xA5, last=1, UartTx TICKS_PER_CYCLE=4.
  - Required: reqReady[0] pulses once; serialOut shows start bit, then 1,0,1,0,0,1,0,1, then the stop bit; busy drops after sendComplete clears; grant returns to 0.
- Contention: req0 (0x11), req1 (0x22) and req3 (0x44) all continuously valid with single-byte frames, rrPtr=0.
  - Required: bytes are sent in order 0x11, 0x22, 0x44, 0x11; req2 is never granted.
- Multi-byte frame: req2 sends 0x01, 0x02, 0x03 (last on 0x03) while req0 is valid throughout.
  - Required: all three bytes are sent back-to-back before 0x?? from req0; grant stays 4'b0100 throughout.
- Timeout: req1 sends 0x55 with last=0, then drops reqValid; FRAME_TIMEOUT=20.
  - Required: grant is revoked exactly 20 cycles after entering WAIT_NEXT; a pending req3 is granted next.
- Reset mid-send: assert reset for 1 cycle while in SEND.
  - Required: uartSendRequest=0 on the next cycle and all outputs are reset. A request raised immediately afterwards is not granted until uartSendComplete=0.
- Handshake timing: uartSendComplete stub held high 5 extra cycles.
  - Required: uartSendRequest stays low throughout; the next byte is not issued until uartSendComplete has been low for at least 1 cycle.
